// File: rtl/ahbl_stream_port.sv
// ahbl_stream_port: AHB-Lite responder exposing a TX/RX FIFO pair behind a
// fixed DATA address, with wait-state flow control and an optional stall
// timeout that ends a stuck transfer with a two-cycle ERROR response.

// Single-clock FIFO with a separate level counter and a one-cycle flush.
module ahbl_stream_fifo #(
   parameter int DEPTH = 8,
   parameter int DW    = 32
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic                    flush,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DW-1:0]           wdata,
   output logic [DW-1:0]           rdata,
   output logic [$clog2(DEPTH):0]  level,
   output logic [$clog2(DEPTH):0]  level_nxt,
   output logic                    empty,
   output logic                    full
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   // Flags come from registered level only; a full FIFO never takes a push.
   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Next level, exported so the owner can register flags derived from it.
   always_comb begin
      level_nxt = level;
      if (flush)
         level_nxt = '0;
      else if (do_push && !do_pop)
         level_nxt = level + LW'(1);
      else if (do_pop && !do_push)
         level_nxt = level - LW'(1);
   end

   // Pointer/level state; flush overrides any same-cycle push or pop.
   always_ff @(posedge HCLK) begin
      if (!HRESETn || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt;
      end
   end

   // Storage array; contents need no reset since level gates every read.
   always_ff @(posedge HCLK) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

module ahbl_stream_port #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        HRESP,
   output logic        IRQ,
   output logic        m_valid,
   output logic [31:0] m_data,
   input  logic        m_ready,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   output logic        s_ready
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
   typedef struct packed {
      logic [1:0] addr;
      logic       write;
   } dp_req_t;

   state_t        state;
   dp_req_t       dp;
   logic [CW-1:0] wait_cnt;
   logic          rx_ie, tx_ie, irq_q;

   logic          tx_push, tx_pop, tx_flush, tx_empty, tx_full;
   logic          rx_push, rx_pop, rx_flush, rx_empty, rx_full;
   logic [31:0]   rx_rdata;
   logic [LW-1:0] tx_level, tx_level_nxt, rx_level, rx_level_nxt;
   logic          addr_ok, dp_fifo, stall, tmo, ctrl_wr;
   logic          rx_ie_nxt, tx_ie_nxt;
   logic [31:0]   status;
   logic          unused;

   assign unused = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0]};

   // Bus decode: a stall only exists on a DATA access whose FIFO can't serve.
   assign addr_ok = HSEL & HREADY & HTRANS[1];
   assign dp_fifo = (state == DATA) && (dp.addr == 2'd0);
   assign stall   = dp_fifo && (dp.write ? tx_full : rx_empty);
   assign tmo     = (TIMEOUT != 0) && stall && (wait_cnt == CW'(TIMEOUT - 1));
   assign ctrl_wr = (state == DATA) && dp.write && (dp.addr == 2'd2);

   // Bus responses decode from registered state and FIFO flags only.
   assign HREADYOUT = !(stall || state == ERR1);
   assign HRESP     = (state == ERR1) || (state == ERR2);
   assign IRQ       = irq_q;

   assign tx_push  = dp_fifo & dp.write;
   assign rx_pop   = dp_fifo & ~dp.write;
   assign tx_flush = ctrl_wr & HWDATA[0];
   assign rx_flush = ctrl_wr & HWDATA[1];
   assign m_valid  = ~tx_empty;
   assign tx_pop   = m_valid & m_ready;
   assign s_ready  = ~rx_full;
   assign rx_push  = s_valid & s_ready;

   assign status = {8'h00, 8'(rx_level), 8'(tx_level), 4'h0,
                    rx_full, rx_empty, tx_full, tx_empty};

   ahbl_stream_fifo #(.DEPTH(DEPTH), .DW(32)) u_tx (
      .HCLK(HCLK), .HRESETn(HRESETn), .flush(tx_flush), .push(tx_push),
      .pop(tx_pop), .wdata(HWDATA), .rdata(m_data), .level(tx_level),
      .level_nxt(tx_level_nxt), .empty(tx_empty), .full(tx_full));

   ahbl_stream_fifo #(.DEPTH(DEPTH), .DW(32)) u_rx (
      .HCLK(HCLK), .HRESETn(HRESETn), .flush(rx_flush), .push(rx_push),
      .pop(rx_pop), .wdata(s_data), .rdata(rx_rdata), .level(rx_level),
      .level_nxt(rx_level_nxt), .empty(rx_empty), .full(rx_full));

   // Read mux; anything other than a completing data-phase read returns 0.
   always_comb begin
      HRDATA = '0;
      if (state == DATA && !dp.write) begin
         case (dp.addr)
            2'd0:    HRDATA = rx_empty ? '0 : rx_rdata;
            2'd1:    HRDATA = status;
            2'd2:    HRDATA = {28'h0, tx_ie, rx_ie, 2'b00};
            default: HRDATA = 32'hDEAD_BEEF;
         endcase
      end
   end

   // Transfer FSM: new address phases are taken whenever we present ready.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state    <= IDLE;
         dp       <= '0;
         wait_cnt <= '0;
      end else if (HREADYOUT && addr_ok) begin
         state    <= DATA;
         dp       <= '{addr: HADDR[3:2], write: HWRITE};
         wait_cnt <= '0;
      end else begin
         case (state)
            DATA: begin
               if (tmo)        state    <= ERR1;
               else if (stall) wait_cnt <= wait_cnt + CW'(1);
               else            state    <= IDLE;
            end
            ERR1:    state <= ERR2;
            default: state <= IDLE;
         endcase
      end
   end

   // CTRL enables and IRQ; IRQ tracks post-edge FIFO state with no extra lag.
   assign rx_ie_nxt = ctrl_wr ? HWDATA[2] : rx_ie;
   assign tx_ie_nxt = ctrl_wr ? HWDATA[3] : tx_ie;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         rx_ie <= 1'b0;
         tx_ie <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         rx_ie <= rx_ie_nxt;
         tx_ie <= tx_ie_nxt;
         irq_q <= (rx_ie_nxt & (rx_level_nxt != '0)) |
                  (tx_ie_nxt & (tx_level_nxt != LW'(DEPTH)));
      end
   end
endmodule

// File: tb/tb_ahbl_stream_port.sv
// tb_ahbl_stream_port: directed and randomized bus/stream traffic, checked
// against a queue-based model of the port's register and FIFO behaviour.
module tb_ahbl_stream_port;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic        HCLK = 1'b0, HRESETn = 1'b0;
   logic        HSEL = 1'b0, HWRITE = 1'b0;
   logic [31:0] HADDR = '0, HWDATA = '0;
   logic [1:0]  HTRANS = 2'b00;
   logic [2:0]  HSIZE = 3'b010;
   logic        HREADY, HREADYOUT, HRESP, IRQ;
   logic [31:0] HRDATA, m_data;
   logic        m_valid, m_ready = 1'b0, s_valid = 1'b0, s_ready;
   logic [31:0] s_data = '0;

   assign HREADY = HREADYOUT;
   always #5 HCLK = ~HCLK;

   ahbl_stream_port #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
      .IRQ(IRQ), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready));

   // reference model state
   logic [31:0] txq[$], rxq[$], rd_log[$];
   int          wt_log[$];
   bit          rx_ie, tx_ie, dp_wr, acc_flag, rnd_stream, last_err;
   logic [1:0]  dp_a;
   int          ph;             // 0 idle, 1 data phase, 2 error cycle 1, 3 error cycle 2
   int          mwaits, obs_waits, last_waits;
   logic [31:0] last_rd;
   int          n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] stat(input int tn, input int rn);
      return {8'h00, 8'(rn), 8'(tn), 4'h0, rn == DEPTH, rn == 0, tn == DEPTH, tn == 0};
   endfunction

   // One clock: check outputs against the model, advance model, cross the edge.
   task automatic step();
      int tn, rn;
      bit rdy, tpop, rpush, bpush, bpop, tfl, rfl, rst, done;
      logic [31:0] exp_rd;
      if (rnd_stream) begin
         m_ready = ($urandom_range(0, 2) != 0);
         s_valid = ($urandom_range(0, 1) != 0);
         s_data  = $urandom;
      end
      tn = txq.size(); rn = rxq.size(); rst = !HRESETn;
      chk("m_valid", m_valid, tn > 0);
      chk("s_ready", s_ready, rn < DEPTH);
      tpop  = m_ready && tn > 0;
      rpush = s_valid && rn < DEPTH;
      if (tpop) chk("m_data", m_data, txq[0]);
      rdy = 1; bpush = 0; bpop = 0; tfl = 0; rfl = 0; done = 0;
      case (ph)
         0: begin chk("idle_ready", HREADYOUT, 1); chk("idle_resp", HRESP, 0); end
         2: begin rdy = 0; chk("err1_ready", HREADYOUT, 0); chk("err1_resp", HRESP, 1); end
         3: begin chk("err2_ready", HREADYOUT, 1); chk("err2_resp", HRESP, 1); end
         default: begin
            if (dp_a == 2'd0) rdy = dp_wr ? (tn < DEPTH) : (rn > 0);
            chk("dp_ready", HREADYOUT, rdy);
            chk("dp_resp", HRESP, 0);
            if (!dp_wr) begin
               case (dp_a)
                  2'd0:    exp_rd = rdy ? rxq[0] : 32'h0;
                  2'd1:    exp_rd = stat(tn, rn);
                  2'd2:    exp_rd = {28'h0, tx_ie, rx_ie, 2'b00};
                  default: exp_rd = 32'hDEAD_BEEF;
               endcase
               chk($sformatf("rdata_a%0d", dp_a), HRDATA, exp_rd);
            end
            if (HREADYOUT === 1'b0) obs_waits++;
            if (rdy) begin
               done = 1; last_err = 0; last_waits = obs_waits; wt_log.push_back(obs_waits);
               if (!dp_wr) begin last_rd = HRDATA; rd_log.push_back(HRDATA); end
               if (dp_a == 2'd0) begin bpush = dp_wr; bpop = !dp_wr; end
               if (dp_a == 2'd2 && dp_wr) begin tfl = HWDATA[0]; rfl = HWDATA[1]; end
            end else
               mwaits++;
         end
      endcase
      acc_flag = !rst && rdy && HSEL && HTRANS[1];
      if (ph == 1 && done && dp_a == 2'd2 && dp_wr) begin rx_ie = HWDATA[2]; tx_ie = HWDATA[3]; end
      if (tfl) txq.delete();
      else begin
         if (tpop) void'(txq.pop_front());
         if (bpush) txq.push_back(HWDATA);
      end
      if (rfl) rxq.delete();
      else begin
         if (bpop) void'(rxq.pop_front());
         if (rpush) rxq.push_back(s_data);
      end
      if (acc_flag) begin
         ph = 1; dp_wr = HWRITE; dp_a = HADDR[3:2]; mwaits = 0; obs_waits = 0;
      end else if (ph == 1 && !rdy) begin
         if (mwaits == TIMEOUT) begin ph = 2; last_err = 1; last_waits = obs_waits; end
      end else if (ph == 2) ph = 3;
      else ph = 0;
      @(posedge HCLK); #1;
      if (rst) begin
         txq.delete(); rxq.delete(); rx_ie = 0; tx_ie = 0; ph = 0; acc_flag = 0;
      end
      chk("irq", IRQ, (rx_ie && rxq.size() > 0) || (tx_ie && txq.size() < DEPTH));
   endtask

   task automatic bus_addr(input bit wr, input logic [3:0] a, input logic [31:0] wd);
      HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = {28'h0, a};
      acc_flag = 0;
      for (int i = 0; i < 64 && !acc_flag; i++) step();
      if (!acc_flag) chk("addr_accept", acc_flag, 1);
      HSEL = 0; HTRANS = 2'b00; HWDATA = wd;
   endtask

   task automatic bus_finish();
      for (int i = 0; i < 100 && (ph == 1 || ph == 2); i++) step();
      if (ph == 1 || ph == 2) chk("finish_bound", ph, 3);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      bus_addr(1, a, d); bus_finish();
   endtask

   task automatic rd(input logic [3:0] a);
      bus_addr(0, a, 32'h0); bus_finish();
   endtask

   logic [31:0] pat[4] = '{32'h11, 32'h22, 32'h33, 32'h44};

   initial begin
      ph = 0; rnd_stream = 0;
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_ready", HREADYOUT, 1); chk("rst_resp", HRESP, 0);
      chk("rst_rdata", HRDATA, 0);    chk("rst_irq", IRQ, 0);
      chk("rst_mvalid", m_valid, 0);  chk("rst_sready", s_ready, 1);
      HRESETn = 1;

      // fill TX with the consumer stalled, then drain in order
      for (int i = 0; i < 4; i++) begin
         wr(4'h0, pat[i]);
         chk($sformatf("fill_waits%0d", i), last_waits, 0);
      end
      rd(4'h4);
      chk("status_txfull", last_rd, 32'h0000_0406);
      m_ready = 1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain%0d", i), m_data, pat[i]);
         step();
      end
      m_ready = 0;

      // write into a full TX, released by a single consumer beat
      for (int i = 0; i < 4; i++) wr(4'h0, pat[i]);
      bus_addr(1, 4'h0, 32'h55);
      repeat (3) step();
      m_ready = 1; step(); m_ready = 0;
      bus_finish();
      chk("full_wr_waits", last_waits, 4);
      chk("full_wr_head", m_data, 32'h22);
      m_ready = 1; repeat (4) step(); m_ready = 0;

      // read of an empty RX times out into ERROR
      rd(4'h0);
      chk("tmo_waits", last_waits, TIMEOUT);
      chk("tmo_err2_resp", HRESP, 1);
      chk("tmo_err2_ready", HREADYOUT, 1);
      step();
      rd(4'h4);
      chk("tmo_rx_level", (last_rd >> 16) & 32'hFF, 0);

      // back-to-back reads: first served at once, second waits for a beat
      s_valid = 1; s_data = 32'hA5A5_A5A5; step(); s_valid = 0;
      rd_log.delete(); wt_log.delete();
      bus_addr(0, 4'h0, 0);
      bus_addr(0, 4'h0, 0);
      repeat (3) step();
      s_valid = 1; s_data = 32'h5A5A_5A5A; step(); s_valid = 0;
      bus_finish();
      chk("b2b_rd0", rd_log[0], 32'hA5A5_A5A5);
      chk("b2b_wt0", wt_log[0], 0);
      chk("b2b_rd1", rd_log[1], 32'h5A5A_5A5A);
      chk("b2b_wt1", wt_log[1], 4);

      // RX interrupt enable, then flush clears it
      wr(4'h8, 32'h4);
      step();
      chk("irq_rx_empty", IRQ, 0);
      s_valid = 1; s_data = 32'h1234; step(); s_valid = 0;
      chk("irq_rx_beat", IRQ, 1);
      wr(4'h8, 32'h6);
      chk("irq_after_flush", IRQ, 0);
      rd(4'h4);
      chk("flush_rx_empty", (last_rd >> 2) & 32'h1, 1);

      // reset while a read is stalled, with TX holding data
      wr(4'h0, 32'h77);
      bus_addr(0, 4'h0, 0);
      repeat (2) step();
      HRESETn = 0; step(); HRESETn = 1;
      chk("mrst_ready", HREADYOUT, 1);
      chk("mrst_resp", HRESP, 0);
      rd(4'h4);
      chk("mrst_status", last_rd, 32'h0000_0005);

      // randomized traffic with random stream handshakes and pipelining
      rnd_stream = 1;
      for (int i = 0; i < 150; i++) begin
         int op;
         logic [31:0] r;
         op = $urandom_range(0, 9);
         r = $urandom;
         case (op)
            0, 1, 2, 3: bus_addr(1, 4'h0, r);
            4, 5, 6:    bus_addr(0, 4'h0, 0);
            7:          bus_addr(0, 4'h4, 0);
            8:          bus_addr(1, 4'h8, (r & 32'hC) | (($urandom_range(0, 5) == 0) ? (r & 32'h3) : 32'h0));
            default:    bus_addr(0, 4'h8, 0);
         endcase
         if ($urandom_range(0, 1) != 0) bus_finish();
      end
      bus_finish();
      rnd_stream = 0; m_ready = 0; s_valid = 0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
